// File: rtl/present_round_sched.sv
// present_round_sched
// Sequencing controller and two-way round-robin arbiter for an iterative
// PRESENT-128 round datapath. A granted job is loaded into the datapath in
// its accept cycle. The scheduler then issues ceil(31/ROUNDS_PER_CYCLE) step
// commands. The ciphertext is returned with the requester id on a
// valid/ready output port.
//
// Handshake semantics (both ports): a transfer happens in a cycle where valid
// and ready are both 1 at the rising edge. A requester may withdraw valid at
// any time before its transfer. req_ready is asserted only towards the
// arbitration winner, and only while that requester's valid is high.
// out_valid stays high and out_data/out_id stay stable until out_ready is seen.
module present_round_sched #(
  parameter int ROUNDS_PER_CYCLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0][63:0]  req_data,
  input  logic [1:0][127:0] req_key,
  output logic              dp_load,
  output logic [63:0]       dp_data,
  output logic [127:0]      dp_key,
  output logic              dp_en,
  output logic [4:0]        dp_round_base,
  output logic [4:0]        dp_nrounds,
  output logic              dp_last,
  input  logic [63:0]       dp_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_data,
  output logic              out_id,
  output logic              busy
);

  // The datapath can execute at most 31 rounds in one step, and at least one.
  if (ROUNDS_PER_CYCLE < 1 || ROUNDS_PER_CYCLE > 31) begin : g_bad_rounds
    $error("present_round_sched: ROUNDS_PER_CYCLE must be in 1..31");
  end

  localparam logic [5:0] STEP6 = 6'(ROUNDS_PER_CYCLE);
  localparam logic [4:0] STEP5 = STEP6[4:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_base;        // round number of the first round in the next step
  logic [4:0] w_base_nxt;
  logic       r_last_grant;  // requester that won the previous arbitration
  logic       r_id;          // requester of the job in flight

  logic       w_arb_open;    // this cycle may accept a new job
  logic       w_win;         // arbitration winner (meaningful when w_grant)
  logic       w_grant;       // a job is accepted this cycle
  logic [5:0] w_sum;         // base + step, 6 bits so 31+step does not wrap
  logic       w_is_last;     // this step reaches round 31

  // Arbitration window: idle, or the cycle in which the finished result is
  // handed off. Nothing is accepted while reset is asserted.
  always_comb begin
    w_arb_open = !rst && ((r_state == S_IDLE) ||
                          ((r_state == S_DONE) && out_ready));
  end

  // Round-robin pick: a sole requester wins; on a tie, the requester that did
  // not win last time wins.
  always_comb begin
    w_win = 1'b0;
    case (req_valid)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last_grant;
      default: w_win = 1'b0;
    endcase
    w_grant = w_arb_open && (req_valid != 2'b00);
  end

  // Step arithmetic for the RUN state.
  always_comb begin
    w_sum     = {1'b0, r_base} + STEP6;
    w_is_last = (w_sum > 6'd31);
  end

  // Next-state logic and all command and output values.
  always_comb begin
    w_state_nxt   = r_state;
    w_base_nxt    = r_base;
    req_ready     = 2'b00;
    dp_load       = 1'b0;
    dp_data       = '0;
    dp_key        = '0;
    dp_en         = 1'b0;
    dp_round_base = '0;
    dp_nrounds    = '0;
    dp_last       = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_id        = 1'b0;

    // The winner's job is loaded in the same cycle it is accepted.
    if (w_grant) begin
      req_ready[w_win] = 1'b1;
      dp_load          = 1'b1;
      dp_data          = req_data[w_win];
      dp_key           = req_key[w_win];
    end

    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        dp_en         = 1'b1;
        dp_round_base = r_base;
        dp_last       = w_is_last;
        // The last step may be shorter: only rounds up to 31 remain.
        dp_nrounds    = w_is_last ? 5'(6'd32 - {1'b0, r_base}) : STEP5;
        w_base_nxt    = w_sum[4:0];
        if (w_is_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // dp_result still holds this job's ciphertext. A load issued in the
        // hand-off cycle only takes effect at the following edge.
        out_valid = 1'b1;
        out_data  = dp_result;
        out_id    = r_id;
        if (out_ready) begin
          w_state_nxt = w_grant ? S_RUN : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, round base and arbitration history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_base       <= 5'd1;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_grant ? 5'd1 : w_base_nxt;
      if (w_grant) begin
        r_last_grant <= w_win;
        r_id         <= w_win;
      end
    end
  end

  // Busy whenever a job is running or its result is waiting.
  always_comb begin
    busy = (r_state != S_IDLE);
  end

endmodule
